ring_sequence_checker: RTL and testbench

//  Receive-side companion to the 4-bit one-hot ring counter. Samples a one-hot

---
 rtl/ring_sequence_checker.sv | 133 +++++++++++++
 tb/tb_ring_sequence_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker
// Sink-side monitor for a one-hot ring counter bus. Decodes each enabled
// sample to a binary index, tracks the expected next rotation and locks once
// enough consecutive samples have rotated correctly. While locked, it counts
// completed revolutions and flags any break in the sequence.
module ring_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Ring_In,
  output logic [IDX_W-1:0] Index,
  output logic             Onehot_Ok,
  output logic             Locked,
  output logic             Seq_Err,
  output logic [7:0]       Rev_Count,
  output logic [7:0]       Err_Count
);

  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int STREAK_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [WIDTH-1:0]    expected;

  logic [CNT_W-1:0]    hot_count;
  logic [IDX_W-1:0]    hot_pos;
  logic                valid;
  logic [WIDTH-1:0]    rotated;
  logic [STREAK_W-1:0] hunt_streak;

  // Decode the incoming sample: population count, set-bit position, next rotation.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hot_count = '0;
    hot_pos   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (Ring_In[i]) begin
        hot_count = hot_count + 1'b1;
        hot_pos   = IDX_W'(i);
      end
    end
    valid   = (hot_count == CNT_W'(1));
    rotated = {Ring_In[WIDTH-2:0], Ring_In[WIDTH-1]};
    // A streak only extends when the previous sample predicted this one;
    // it never exceeds LOCK_COUNT because reaching it leaves HUNT.
    if ((streak != '0) && (Ring_In == expected)) begin
      hunt_streak = streak + 1'b1;
    end else begin
      hunt_streak = STREAK_W'(1);
    end
  end

  // Lock state machine, decoded outputs and revolution/error counters.
  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (Reset) begin
      state     <= HUNT;
      streak    <= '0;
      expected  <= '0;
      Index     <= '0;
      Onehot_Ok <= 1'b0;
      Locked    <= 1'b0;
      Seq_Err   <= 1'b0;
      Rev_Count <= '0;
      Err_Count <= '0;
    end else begin
      Seq_Err <= 1'b0;
      if (Enable) begin
        // Index keeps the last valid position across invalid samples.
        if (valid) begin
          Onehot_Ok <= 1'b1;
          Index     <= hot_pos;
        end else begin
          Onehot_Ok <= 1'b0;
        end

        case (state)
          HUNT: begin
            if (!valid) begin
              streak <= '0;
            end else begin
              streak   <= hunt_streak;
              expected <= rotated;
              // The locking sample itself never counts a revolution.
              if (hunt_streak == STREAK_W'(LOCK_COUNT)) begin
                state  <= LOCKED;
                Locked <= 1'b1;
              end
            end
          end

          LOCKED: begin
            // expected is always one-hot here, so equality implies a valid sample.
            if (Ring_In == expected) begin
              expected <= rotated;
              if (Ring_In[0]) begin
                Rev_Count <= Rev_Count + 8'd1;
              end
            end else begin
              Seq_Err <= 1'b1;
              if (Err_Count != 8'hFF) begin
                Err_Count <= Err_Count + 8'd1;
              end
              Locked <= 1'b0;
              state  <= HUNT;
              if (valid) begin
                streak   <= STREAK_W'(1);
                expected <= rotated;
              end else begin
                streak <= '0;
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb_ring_sequence_checker
// Directed scenarios with spec-derived constants, followed by randomized
// traffic checked against a position-based behavioural model.
module tb_ring_sequence_checker;

  localparam int W  = 4;
  localparam int LC = 2;

  logic         clk;
  logic         Reset;
  logic         Enable;
  logic [W-1:0] Ring_In;
  logic [1:0]   Index;
  logic         Onehot_Ok;
  logic         Locked;
  logic         Seq_Err;
  logic [7:0]   Rev_Count;
  logic [7:0]   Err_Count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the ring position is tracked as an integer index.
  int m_index, m_ok, m_locked, m_seq, m_rev, m_err, m_streak, m_exp_pos;

  ring_sequence_checker #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
    .Clock     (clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .Ring_In   (Ring_In),
    .Index     (Index),
    .Onehot_Ok (Onehot_Ok),
    .Locked    (Locked),
    .Seq_Err   (Seq_Err),
    .Rev_Count (Rev_Count),
    .Err_Count (Err_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input logic rst, input logic en, input logic [W-1:0] ring);
    int cnt;
    int pos;
    bit ok;
    cnt = 0;
    pos = 0;
    for (int i = 0; i < W; i++) if (ring[i]) begin cnt++; pos = i; end
    ok = (cnt == 1);
    if (rst) begin
      m_index = 0; m_ok = 0; m_locked = 0; m_seq = 0;
      m_rev = 0; m_err = 0; m_streak = 0; m_exp_pos = -1;
    end else if (!en) begin
      m_seq = 0;
    end else begin
      m_seq = 0;
      m_ok  = ok ? 1 : 0;
      if (ok) m_index = pos;
      if (m_locked == 0) begin
        if (!ok) m_streak = 0;
        else begin
          m_streak  = (m_streak > 0 && pos == m_exp_pos) ? m_streak + 1 : 1;
          m_exp_pos = (pos + 1) % W;
          if (m_streak == LC) m_locked = 1;
        end
      end else if (ok && pos == m_exp_pos) begin
        m_exp_pos = (pos + 1) % W;
        if (pos == 0) m_rev = (m_rev + 1) % 256;
      end else begin
        m_seq    = 1;
        m_err    = (m_err < 255) ? m_err + 1 : 255;
        m_locked = 0;
        m_streak = ok ? 1 : 0;
        if (ok) m_exp_pos = (pos + 1) % W;
      end
    end
  endtask

  // Drive one sample at the falling edge; outputs are settled 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic en, input logic [W-1:0] ring);
    @(negedge clk);
    Reset   = rst;
    Enable  = en;
    Ring_In = ring;
    @(posedge clk);
    model_update(rst, en, ring);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 4'b0101);
    n_checks++; if (Index !== 2'd0)     begin n_fail++; $display("FAIL reset_index: got %0d want 0", Index); end
    n_checks++; if (Onehot_Ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %0b want 0", Onehot_Ok); end
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL reset_locked: got %0b want 0", Locked); end
    n_checks++; if (Seq_Err !== 1'b0)   begin n_fail++; $display("FAIL reset_seq_err: got %0b want 0", Seq_Err); end
    n_checks++; if (Rev_Count !== 8'd0) begin n_fail++; $display("FAIL reset_rev: got %0d want 0", Rev_Count); end
    n_checks++; if (Err_Count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", Err_Count); end
  endtask

  task automatic test_lock();
    step(1'b0, 1'b1, 4'b0001);
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL lock_first_locked: got %0b want 0", Locked); end
    n_checks++; if (Onehot_Ok !== 1'b1) begin n_fail++; $display("FAIL lock_first_ok: got %0b want 1", Onehot_Ok); end
    step(1'b0, 1'b1, 4'b0010);
    n_checks++; if (Locked !== 1'b1)    begin n_fail++; $display("FAIL lock_second_locked: got %0b want 1", Locked); end
    n_checks++; if (Index !== 2'd1)     begin n_fail++; $display("FAIL lock_second_index: got %0d want 1", Index); end
    n_checks++; if (Rev_Count !== 8'd0) begin n_fail++; $display("FAIL lock_second_rev: got %0d want 0", Rev_Count); end
  endtask

  task automatic test_rotate();
    logic [W-1:0] pats [3] = '{4'b0100, 4'b1000, 4'b0001};
    int           idxs [3] = '{2, 3, 0};
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, pats[k]);
      n_checks++; if (Index !== 2'(idxs[k])) begin n_fail++; $display("FAIL rotate_index%0d: got %0d want %0d", k, Index, idxs[k]); end
      n_checks++; if (Seq_Err !== 1'b0)      begin n_fail++; $display("FAIL rotate_seq_err%0d: got %0b want 0", k, Seq_Err); end
      n_checks++; if (Locked !== 1'b1)       begin n_fail++; $display("FAIL rotate_locked%0d: got %0b want 1", k, Locked); end
    end
    n_checks++; if (Rev_Count !== 8'd1) begin n_fail++; $display("FAIL rotate_rev: got %0d want 1", Rev_Count); end
  endtask

  task automatic test_bad_pattern();
    step(1'b0, 1'b1, 4'b0110);
    n_checks++; if (Seq_Err !== 1'b1)   begin n_fail++; $display("FAIL bad_seq_err: got %0b want 1", Seq_Err); end
    n_checks++; if (Err_Count !== 8'd1) begin n_fail++; $display("FAIL bad_err_count: got %0d want 1", Err_Count); end
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL bad_locked: got %0b want 0", Locked); end
    n_checks++; if (Onehot_Ok !== 1'b0) begin n_fail++; $display("FAIL bad_ok: got %0b want 0", Onehot_Ok); end
    n_checks++; if (Index !== 2'd0)     begin n_fail++; $display("FAIL bad_index_hold: got %0d want 0", Index); end
    step(1'b0, 1'b1, 4'b0001);
    n_checks++; if (Seq_Err !== 1'b0)   begin n_fail++; $display("FAIL bad_pulse_width: got %0b want 0", Seq_Err); end
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL bad_relock_early: got %0b want 0", Locked); end
    step(1'b0, 1'b1, 4'b0010);
    n_checks++; if (Locked !== 1'b1)    begin n_fail++; $display("FAIL bad_relock: got %0b want 1", Locked); end
    n_checks++; if (Rev_Count !== 8'd1) begin n_fail++; $display("FAIL bad_rev_hold: got %0d want 1", Rev_Count); end
  endtask

  task automatic test_skip();
    step(1'b0, 1'b1, 4'b0100);
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b1, 4'b0001);
    n_checks++; if (Rev_Count !== 8'd2) begin n_fail++; $display("FAIL skip_rev: got %0d want 2", Rev_Count); end
    step(1'b0, 1'b1, 4'b0100);
    n_checks++; if (Seq_Err !== 1'b1)   begin n_fail++; $display("FAIL skip_seq_err: got %0b want 1", Seq_Err); end
    n_checks++; if (Err_Count !== 8'd2) begin n_fail++; $display("FAIL skip_err_count: got %0d want 2", Err_Count); end
    n_checks++; if (Index !== 2'd2)     begin n_fail++; $display("FAIL skip_index: got %0d want 2", Index); end
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL skip_locked: got %0b want 0", Locked); end
    step(1'b0, 1'b1, 4'b1000);
    n_checks++; if (Locked !== 1'b1)    begin n_fail++; $display("FAIL skip_relock: got %0b want 1", Locked); end
    n_checks++; if (Seq_Err !== 1'b0)   begin n_fail++; $display("FAIL skip_seq_clear: got %0b want 0", Seq_Err); end
  endtask

  task automatic test_enable_hold();
    logic [1:0] s_index;
    logic [7:0] s_rev, s_err;
    s_index = Index; s_rev = Rev_Count; s_err = Err_Count;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, W'($urandom));
      n_checks++; if (Index !== s_index)   begin n_fail++; $display("FAIL hold_index%0d: got %0d want %0d", k, Index, s_index); end
      n_checks++; if (Onehot_Ok !== 1'b1)  begin n_fail++; $display("FAIL hold_ok%0d: got %0b want 1", k, Onehot_Ok); end
      n_checks++; if (Locked !== 1'b1)     begin n_fail++; $display("FAIL hold_locked%0d: got %0b want 1", k, Locked); end
      n_checks++; if (Seq_Err !== 1'b0)    begin n_fail++; $display("FAIL hold_seq_err%0d: got %0b want 0", k, Seq_Err); end
      n_checks++; if (Rev_Count !== s_rev) begin n_fail++; $display("FAIL hold_rev%0d: got %0d want %0d", k, Rev_Count, s_rev); end
      n_checks++; if (Err_Count !== s_err) begin n_fail++; $display("FAIL hold_err%0d: got %0d want %0d", k, Err_Count, s_err); end
    end
    step(1'b0, 1'b1, 4'b0001);
    n_checks++; if (Seq_Err !== 1'b0)   begin n_fail++; $display("FAIL hold_resume_seq: got %0b want 0", Seq_Err); end
    n_checks++; if (Locked !== 1'b1)    begin n_fail++; $display("FAIL hold_resume_locked: got %0b want 1", Locked); end
    n_checks++; if (Rev_Count !== 8'd3) begin n_fail++; $display("FAIL hold_resume_rev: got %0d want 3", Rev_Count); end
  endtask

  task automatic test_saturation_reset();
    // Locked at 0001: each round breaks the lock with an all-zero sample, then relocks.
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0010);
    end
    n_checks++; if (Err_Count !== 8'd255) begin n_fail++; $display("FAIL sat_err_count: got %0d want 255", Err_Count); end
    n_checks++; if (Locked !== 1'b1)      begin n_fail++; $display("FAIL sat_locked: got %0b want 1", Locked); end
    step(1'b0, 1'b1, 4'b0100);
    step(1'b1, 1'b1, 4'b1000);
    n_checks++; if (Index !== 2'd0)     begin n_fail++; $display("FAIL mid_reset_index: got %0d want 0", Index); end
    n_checks++; if (Onehot_Ok !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ok: got %0b want 0", Onehot_Ok); end
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL mid_reset_locked: got %0b want 0", Locked); end
    n_checks++; if (Rev_Count !== 8'd0) begin n_fail++; $display("FAIL mid_reset_rev: got %0d want 0", Rev_Count); end
    n_checks++; if (Err_Count !== 8'd0) begin n_fail++; $display("FAIL mid_reset_err: got %0d want 0", Err_Count); end
    // Back in HUNT with streak 0: one valid sample must not lock.
    step(1'b0, 1'b1, 4'b0001);
    n_checks++; if (Locked !== 1'b0)    begin n_fail++; $display("FAIL mid_reset_hunt: got %0b want 0", Locked); end
  endtask

  task automatic test_random();
    logic [W-1:0] pat;
    logic         rst, en;
    int           r;
    for (int k = 0; k < 3000; k++) begin
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      en  = ($urandom_range(0, 9) != 0);
      r   = $urandom_range(0, 99);
      if (r < 65 && m_exp_pos >= 0) pat = W'(1 << m_exp_pos);
      else if (r < 85)              pat = W'(1 << $urandom_range(0, W - 1));
      else                          pat = W'($urandom);
      step(rst, en, pat);
      n_checks++;
      if (Index !== 2'(m_index) || Onehot_Ok !== 1'(m_ok) || Locked !== 1'(m_locked) ||
          Seq_Err !== 1'(m_seq) || Rev_Count !== 8'(m_rev) || Err_Count !== 8'(m_err)) begin
        n_fail++;
        $display("FAIL random%0d: got idx=%0d ok=%0b lk=%0b se=%0b rev=%0d err=%0d want idx=%0d ok=%0d lk=%0d se=%0d rev=%0d err=%0d",
                 k, Index, Onehot_Ok, Locked, Seq_Err, Rev_Count, Err_Count,
                 m_index, m_ok, m_locked, m_seq, m_rev, m_err);
      end
    end
  endtask

  initial begin
    Reset   = 1'b1;
    Enable  = 1'b0;
    Ring_In = '0;
    test_reset();
    test_lock();
    test_rotate();
    test_bad_pattern();
    test_skip();
    test_enable_hold();
    test_saturation_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
